// File: rtl/reg_share_pkg.sv
// rtl/reg_share_pkg.sv - shared types and constants for the register-sharing arbiter
package reg_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAP  = 2'd1,
    WR   = 2'd2,
    ACK  = 2'd3
  } state_t;

  localparam int DEF_NREQ = 4;
  localparam int DEF_W    = 4;
  // Wide enough to name any of up to 8 requesters
  localparam int OWNER_W  = 3;

endpackage

// File: rtl/reg_share_reg.sv
// rtl/reg_share_reg.sv - the shared W-bit enabled register bank
module reg_share_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Load d only when the arbiter opens the enable; reset clears immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational winner select; REG_SHARE_FIXED_PRIO_EN picks lowest index
module rr_picker
  import reg_share_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0]    req,
  input  logic [OWNER_W-1:0] ptr,
  output logic [OWNER_W-1:0] winner,
  output logic               valid
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef REG_SHARE_FIXED_PRIO_EN
  // Priority is fixed, so the rotation pointer carries no information here
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Lowest asserted index wins: scan downward so the last hit is the lowest
  always_comb begin
    winner = '0;
    valid  = |req;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[k]) winner = OWNER_W'(k);
    end
  end
`else
  // First asserted request at or above ptr, wrapping from NREQ-1 back to 0
  always_comb begin
    int  idx;
    logic found;
    winner = '0;
    valid  = |req;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[IW'(idx)]) begin
        winner = OWNER_W'(idx);
        found  = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/reg_share_arbiter.sv
// rtl/reg_share_arbiter.sv - request/grant sharing of one register; REG_SHARE_FIXED_PRIO_EN selects fixed priority
module reg_share_arbiter
  import reg_share_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int W    = DEF_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*W-1:0]   data,
  output logic [NREQ-1:0]     gnt,
  output logic                busy,
  output logic [W-1:0]        q,
  output logic [OWNER_W-1:0]  owner
);

  state_t             state;
  logic [OWNER_W-1:0] sel;
  logic [OWNER_W-1:0] ptr;
  logic [OWNER_W-1:0] winner;
  logic               any_req;
  logic [W-1:0]       hold;
  logic [W-1:0]       win_data;
  logic               reg_en;

  rr_picker #(.NREQ(NREQ)) u_picker (
    .req    (req),
    .ptr    (ptr),
    .winner (winner),
    .valid  (any_req)
  );

  // Route the winning requester's slice of the flattened data bus
  always_comb begin
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == OWNER_W'(i)) win_data = data[i*W +: W];
    end
  end

  // Write sequencer: sample and latch in IDLE, settle, write, acknowledge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sel   <= '0;
      hold  <= '0;
      gnt   <= '0;
      busy  <= 1'b0;
      owner <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            sel   <= winner;
            hold  <= win_data;
            busy  <= 1'b1;
            state <= CAP;
          end
        end
        CAP: state <= WR;
        WR: begin
          owner <= sel;
          gnt   <= NREQ'(1) << sel;
          state <= ACK;
        end
        ACK: begin
          gnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef REG_SHARE_FIXED_PRIO_EN
  assign ptr = '0;
`else
  // Rotate priority past the requester just served
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr <= '0;
    else if (state == ACK) ptr <= (int'(sel) == NREQ - 1) ? '0 : sel + 1'b1;
  end
`endif

  // The register loads only in WR, so a reset before then discards the write
  assign reg_en = (state == WR);

  reg_share_reg #(.W(W)) u_reg (
    .clk   (clk),
    .reset (reset),
    .en    (reg_en),
    .d     (hold),
    .q     (q)
  );

endmodule
